// File: rtl/yarvi_host_master.sv
// Host-side bus master: turns host commands into single outstanding core bus transactions.
// Optional read-response timeout is enabled by defining YARVI_HOST_MASTER_TIMEOUT_EN.
module yarvi_host_master #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_address,
   input  logic [31:0] cmd_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_error,
   input  logic        bus_req_ready,
   output logic        bus_req_read,
   output logic        bus_req_write,
   output logic [31:0] bus_req_address,
   output logic [31:0] bus_req_data,
   input  logic        bus_res_valid,
   input  logic [31:0] bus_res_data
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   // An out-of-range limit would make the timeout counter unreachable or immediate.
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be in 1..255");
   end

   state_t      state_r, state_s;
   logic        write_r, write_s;
   logic [31:0] address_r, address_s;
   logic [31:0] data_r, data_s;
   logic [31:0] rsp_data_r, rsp_data_s;
   logic        rsp_error_r, rsp_error_s;

`ifdef YARVI_HOST_MASTER_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LIMIT = TIMEOUT_CYCLES[7:0];
   logic [7:0] count_r, count_s;
   logic [7:0] count_inc_s;
`endif

   // Next-state and next-register values for the transaction FSM.
   always_comb begin
      state_s     = state_r;
      write_s     = write_r;
      address_s   = address_r;
      data_s      = data_r;
      rsp_data_s  = rsp_data_r;
      rsp_error_s = rsp_error_r;
`ifdef YARVI_HOST_MASTER_TIMEOUT_EN
      count_s     = count_r;
      count_inc_s = count_r + 8'd1;
`endif
      case (state_r)
         ST_IDLE: begin
            if (cmd_valid) begin
               write_s   = cmd_write;
               address_s = cmd_address;
               data_s    = cmd_data;
               // Misaligned commands never reach the bus.
               if (cmd_address[1:0] != 2'b00) begin
                  state_s     = ST_RESP;
                  rsp_error_s = 1'b1;
                  rsp_data_s  = 32'd0;
               end else begin
                  state_s = ST_REQ;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (bus_req_ready) begin
               if (write_r) begin
                  state_s     = ST_RESP;
                  rsp_error_s = 1'b0;
                  rsp_data_s  = 32'd0;
               end else begin
                  state_s = ST_WAIT;
`ifdef YARVI_HOST_MASTER_TIMEOUT_EN
                  count_s = 8'd0;
`endif
               end
            end else begin
               state_s = ST_REQ;
            end
         end
         ST_WAIT: begin
            if (bus_res_valid) begin
               state_s     = ST_RESP;
               rsp_error_s = 1'b0;
               rsp_data_s  = bus_res_data;
            end else begin
`ifdef YARVI_HOST_MASTER_TIMEOUT_EN
               count_s = count_inc_s;
               if (count_inc_s == TIMEOUT_LIMIT) begin
                  state_s     = ST_RESP;
                  rsp_error_s = 1'b1;
                  rsp_data_s  = 32'd0;
               end else begin
                  state_s = ST_WAIT;
               end
`else
               state_s = ST_WAIT;
`endif
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_RESP;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State and latched transaction registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= ST_IDLE;
         write_r     <= 1'b0;
         address_r   <= 32'd0;
         data_r      <= 32'd0;
         rsp_data_r  <= 32'd0;
         rsp_error_r <= 1'b0;
`ifdef YARVI_HOST_MASTER_TIMEOUT_EN
         count_r     <= 8'd0;
`endif
      end else begin
         state_r     <= state_s;
         write_r     <= write_s;
         address_r   <= address_s;
         data_r      <= data_s;
         rsp_data_r  <= rsp_data_s;
         rsp_error_r <= rsp_error_s;
`ifdef YARVI_HOST_MASTER_TIMEOUT_EN
         count_r     <= count_s;
`endif
      end
   end

   assign cmd_ready       = (state_r == ST_IDLE);
   assign rsp_valid       = (state_r == ST_RESP);
   assign rsp_data        = rsp_data_r;
   assign rsp_error       = rsp_error_r;
   assign bus_req_read    = (state_r == ST_REQ) && !write_r;
   assign bus_req_write   = (state_r == ST_REQ) && write_r;
   assign bus_req_address = address_r;
   assign bus_req_data    = data_r;

endmodule

// File: tb/tb_yarvi_host_master.sv
// Directed scoreboard bench for yarvi_host_master; timeout checks run when
// YARVI_HOST_MASTER_TIMEOUT_EN is defined.
module tb_yarvi_host_master;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_address, cmd_data;
   logic        rsp_valid, rsp_ready, rsp_error;
   logic [31:0] rsp_data;
   logic        bus_req_ready, bus_req_read, bus_req_write;
   logic [31:0] bus_req_address, bus_req_data;
   logic        bus_res_valid;
   logic [31:0] bus_res_data;

   int passed = 0;
   int total  = 0;
   logic [32:0] exp_q[$];

   yarvi_host_master #(.TIMEOUT_CYCLES(4)) dut (
      .clock(clock), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_address(cmd_address), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_error(rsp_error),
      .bus_req_ready(bus_req_ready), .bus_req_read(bus_req_read), .bus_req_write(bus_req_write),
      .bus_req_address(bus_req_address), .bus_req_data(bus_req_data),
      .bus_res_valid(bus_res_valid), .bus_res_data(bus_res_data)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog expired before summary");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_cmd_ready"}, cmd_ready, 32'd1);
      check({tag, "_rsp_valid"}, rsp_valid, 32'd0);
      check({tag, "_rsp_error"}, rsp_error, 32'd0);
      check({tag, "_rsp_data"}, rsp_data, 32'd0);
      check({tag, "_req_read"}, bus_req_read, 32'd0);
      check({tag, "_req_write"}, bus_req_write, 32'd0);
      check({tag, "_req_addr"}, bus_req_address, 32'd0);
      check({tag, "_req_data"}, bus_req_data, 32'd0);
   endtask

   // Present one command for a single accepting cycle and record its expected response.
   task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [32:0] expect_rsp);
      cmd_valid   = 1'b1;
      cmd_write   = wr;
      cmd_address = addr;
      cmd_data    = data;
      exp_q.push_back(expect_rsp);
      check("cmd_ready_idle", cmd_ready, 32'd1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int hold);
      int n = 0;
      logic [32:0] e = 33'd0;
      while (!rsp_valid && n < 50) begin
         tick();
         n++;
      end
      check("rsp_arrives", rsp_valid, 32'd1);
      if (exp_q.size() == 0) begin
         check("sb_nonempty", 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         check("rsp_data", rsp_data, e[31:0]);
         check("rsp_error", rsp_error, {31'd0, e[32]});
      end
      for (int i = 0; i < hold; i++) begin
         tick();
         check("hold_valid", rsp_valid, 32'd1);
         check("hold_data", rsp_data, e[31:0]);
         check("hold_cmd_ready", cmd_ready, 32'd0);
      end
      rsp_ready = 1'b1;
      check("handshake_cmd_ready", cmd_ready, 32'd0);
      tick();
      rsp_ready = 1'b0;
      check("rsp_done", rsp_valid, 32'd0);
      check("back_idle", cmd_ready, 32'd1);
   endtask

   initial begin
      int wr_cycles;
      int wait_cycles;
      reset_n = 1'b0;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = 32'd0; cmd_data = 32'd0;
      rsp_ready = 1'b0; bus_req_ready = 1'b0; bus_res_valid = 1'b0; bus_res_data = 32'd0;
      #1;
      reset_checks("reset");
      tick();
      tick();
      reset_n = 1'b1;
      tick();

      // Read with a stray response in the acceptance cycle, real data two cycles later.
      bus_req_ready = 1'b1;
      send_cmd(1'b0, 32'h0000_0100, 32'd0, {1'b0, 32'hCAFE_F00D});
      check("rd_req_read", bus_req_read, 32'd1);
      check("rd_req_write", bus_req_write, 32'd0);
      check("rd_req_addr", bus_req_address, 32'h0000_0100);
      check("rd_cmd_ready", cmd_ready, 32'd0);
      bus_res_valid = 1'b1;
      bus_res_data  = 32'hDEAD_BEEF;
      tick();
      bus_res_valid = 1'b0;
      check("rd_wait_read_low", bus_req_read, 32'd0);
      check("rd_wait_no_rsp", rsp_valid, 32'd0);
      tick();
      check("rd_wait2_no_rsp", rsp_valid, 32'd0);
      bus_res_valid = 1'b1;
      bus_res_data  = 32'hCAFE_F00D;
      tick();
      bus_res_valid = 1'b0;
      wait_rsp(0);

      // Write stalled by bus_req_ready for four cycles, then response held three cycles.
      bus_req_ready = 1'b0;
      send_cmd(1'b1, 32'h0000_0200, 32'h1234_5678, {1'b0, 32'd0});
      wr_cycles = 0;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) bus_req_ready = 1'b1;
         if (bus_req_write) wr_cycles++;
         check("wr_req_read_low", bus_req_read, 32'd0);
         check("wr_addr_stable", bus_req_address, 32'h0000_0200);
         check("wr_data_stable", bus_req_data, 32'h1234_5678);
         tick();
      end
      check("wr_high_cycles", wr_cycles, 32'd5);
      check("wr_req_write_done", bus_req_write, 32'd0);
      wait_rsp(3);

      // A response arriving while idle must be ignored.
      bus_res_valid = 1'b1;
      bus_res_data  = 32'h5555_AAAA;
      tick();
      bus_res_valid = 1'b0;
      check("idle_res_cmd_ready", cmd_ready, 32'd1);
      check("idle_res_rsp_valid", rsp_valid, 32'd0);

      // Misaligned read: error response next cycle, no bus request.
      bus_req_ready = 1'b1;
      send_cmd(1'b0, 32'h0000_0103, 32'd0, {1'b1, 32'd0});
      check("mis_req_read", bus_req_read, 32'd0);
      check("mis_req_write", bus_req_write, 32'd0);
      check("mis_rsp_valid", rsp_valid, 32'd1);
      wait_rsp(0);

      // Reset while waiting for read data, then a late response and a clean read.
      send_cmd(1'b0, 32'h0000_0300, 32'd0, {1'b0, 32'd0});
      tick();
      reset_n = 1'b0;
      #1;
      reset_checks("midreset");
      exp_q.delete();
      tick();
      reset_n = 1'b1;
      bus_res_valid = 1'b1;
      bus_res_data  = 32'h7777_7777;
      tick();
      bus_res_valid = 1'b0;
      check("late_res_rsp_valid", rsp_valid, 32'd0);
      check("late_res_cmd_ready", cmd_ready, 32'd1);
      send_cmd(1'b0, 32'h0000_0104, 32'd0, {1'b0, 32'h0BAD_F00D});
      tick();
      bus_res_valid = 1'b1;
      bus_res_data  = 32'h0BAD_F00D;
      tick();
      bus_res_valid = 1'b0;
      wait_rsp(0);

`ifdef YARVI_HOST_MASTER_TIMEOUT_EN
      // Timeout after four silent WAIT cycles; later data ignored.
      send_cmd(1'b0, 32'h0000_0400, 32'd0, {1'b1, 32'd0});
      tick();
      wait_cycles = 0;
      while (!rsp_valid && wait_cycles < 20) begin
         tick();
         wait_cycles++;
      end
      check("to_wait_cycles", wait_cycles, 32'd4);
      bus_res_valid = 1'b1;
      bus_res_data  = 32'h9999_9999;
      tick();
      bus_res_valid = 1'b0;
      check("to_late_data", rsp_data, 32'd0);
      wait_rsp(0);

      // Data arriving on the expiry cycle wins over the timeout.
      send_cmd(1'b0, 32'h0000_0404, 32'd0, {1'b0, 32'h1357_9BDF});
      tick();
      tick();
      tick();
      tick();
      check("race_no_rsp_yet", rsp_valid, 32'd0);
      bus_res_valid = 1'b1;
      bus_res_data  = 32'h1357_9BDF;
      tick();
      bus_res_valid = 1'b0;
      wait_rsp(0);
`else
      // Without the timeout a read waits indefinitely for its data.
      send_cmd(1'b0, 32'h0000_0400, 32'd0, {1'b0, 32'h2468_ACE0});
      tick();
      wait_cycles = 0;
      for (int i = 0; i < 12; i++) begin
         if (rsp_valid) wait_cycles++;
         tick();
      end
      check("nto_no_rsp", wait_cycles, 32'd0);
      bus_res_valid = 1'b1;
      bus_res_data  = 32'h2468_ACE0;
      tick();
      bus_res_valid = 1'b0;
      wait_rsp(0);
`endif

      check("sb_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/yarvi_host_master.md
YARVI_HOST_MASTER -- requirements
Module: yarvi_host_master

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  TIMEOUT_CYCLES, 255, read-response wait limit in cycles, range 1..255.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clock  in  1  sole clock; all state on posedge clock.
  reset_n  in  1  reset, asynchronous, active-low.
  cmd_valid  in  1  host command present.
  cmd_ready  out  1  command accepted this cycle when cmd_valid=1.
  cmd_write  in  1  1 = write, 0 = read.
  cmd_address  in  32  byte address.
  cmd_data  in  32  write data.
  rsp_valid  out  1  response present.
  rsp_ready  in  1  host consumes response.
  rsp_data  out  32  read data; 0 for writes and errors.
  rsp_error  out  1  1 = misaligned or timed out.
  bus_req_ready  in  1  core can accept a request.
  bus_req_read  out  1  read request.
  bus_req_write  out  1  write request.
  bus_req_address  out  32  request address.
  bus_req_data  out  32  request write data.
  bus_res_valid  in  1  core read data valid.
  bus_res_data  in  32  core read data.

Function
REQ-003 Block SHALL be the initiator for the core's bus_req/bus_res port: one transaction outstanding at a time.
REQ-004 FSM SHALL have states IDLE, REQ, WAIT, RESP.
REQ-005 cmd_ready SHALL be 1 only in IDLE; on cmd_valid&cmd_ready, cmd fields latch and state moves to REQ, or to RESP with rsp_error=1 and no bus request when cmd_address[1:0]!=0.
REQ-006 In REQ, exactly one of bus_req_read/bus_req_write SHALL be 1, with address/data held stable from latched values until acceptance (bus_req_ready=1 in same cycle).
REQ-007 Accepted write SHALL go to RESP next cycle, rsp_error=0, rsp_data=0; writes expect no bus_res_valid.
REQ-008 Accepted read SHALL go to WAIT; bus_res_valid in the acceptance cycle SHALL be ignored.
REQ-009 In WAIT, bus_res_valid=1 SHALL capture bus_res_data into rsp_data, rsp_error=0, go to RESP.
REQ-010 bus_res_valid outside WAIT SHALL be ignored with no state change.
REQ-011 In RESP, rsp_valid=1 with stable data until rsp_ready=1; then IDLE next cycle; no new cmd accepted in that handshake cycle.
REQ-012 bus_req_read/bus_req_write SHALL be 0 in all states except REQ.
REQ-013 Minimum read latency cmd accept to rsp_valid SHALL be 3 cycles (REQ 1, WAIT >=1, RESP).

Reset
REQ-014 reset_n=0 SHALL immediately force IDLE, cmd_ready=1, rsp_valid=0, rsp_error=0, rsp_data=0, bus_req_read=0, bus_req_write=0, bus_req_address=0, bus_req_data=0, timeout counter=0.
REQ-015 Reset mid-transaction SHALL abandon it; a later bus_res_valid SHALL be ignored per REQ-010.

Configuration
REQ-016 Macro YARVI_HOST_MASTER_TIMEOUT_EN defined: 8-bit counter clears on WAIT entry, increments each WAIT cycle without bus_res_valid; at count TIMEOUT_CYCLES go RESP with rsp_error=1, rsp_data=0; bus_res_valid on the same cycle as expiry wins (no error).
REQ-017 Macro undefined: no counter; WAIT persists until bus_res_valid or reset.

Verification
REQ-018 Read 0x100, bus_req_ready=1, bus_res_valid 2 cycles later with 0xCAFEF00D -> rsp_valid, rsp_data=0xCAFEF00D, rsp_error=0.
REQ-019 Write 0x200 data 0x12345678, bus_req_ready low 4 cycles -> bus_req_write held 5 cycles with stable address/data; rsp_data=0, rsp_error=0.
REQ-020 cmd_address=0x103 -> no bus_req_read/bus_req_write pulse; rsp_error=1 next cycle.
REQ-021 TIMEOUT_EN, TIMEOUT_CYCLES=4, no bus_res_valid -> rsp_error=1 after 4 WAIT cycles; late bus_res_valid ignored.
REQ-022 rsp_ready low 3 cycles -> rsp_valid/rsp_data stable, cmd_ready=0 throughout.
REQ-023 reset_n pulsed low during WAIT -> outputs at reset values immediately; next read completes normally.
